// File: rtl/bf16_add_arbiter.sv
// Round-robin arbiter feeding a shared, fully pipelined bf16 adder.
// Tags travel alongside the adder pipeline so that each result is
// returned to the requester that issued it, in issue order.
module bf16_add_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [16*NREQ-1:0]       req_a,
  input  logic [16*NREQ-1:0]       req_b,
  input  logic [NREQ-1:0]          req_sub,
  output logic                     add_start,
  output logic [15:0]              add_a,
  output logic [15:0]              add_b,
  input  logic [15:0]              add_y,
  input  logic                     add_done,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [15:0]              rsp_data,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_id;
  logic           xfer;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;
  logic           sel_sub;

  logic           start_q;
  logic [15:0]    a_q;
  logic [15:0]    b_q;
  logic [IDW-1:0] id_q;

  logic [LAT-1:0] tag_v_q;
  logic [LAT-1:0] tag_v_d;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [IDW-1:0] tag_id_d [LAT];

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [15:0]    rsp_data_q;
  logic           busy_q;
  logic           busy_d;
  logic           err_q;
  logic           tag_last_v;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    xfer      = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    sel_sub   = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      int unsigned idx;
      idx = (32'(last_grant_q) + off) % NREQ;
      if (!xfer && rst_n && req_valid[idx]) begin
        xfer           = 1'b1;
        req_ready[idx] = 1'b1;
        grant_id       = IDW'(idx);
        sel_a          = req_a[16*idx +: 16];
        sel_b          = req_b[16*idx +: 16];
        sel_sub        = req_sub[idx];
      end
    end
  end

  // Tag pipeline advances every cycle; stage 0 captures the issue slot.
  always_comb begin
    tag_v_d[0]  = start_q;
    tag_id_d[0] = id_q;
    for (int unsigned k = 1; k < LAT; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
    busy_d = xfer | (|tag_v_d);
  end

  assign tag_last_v = tag_v_q[LAT-1];

  // Issue register, tag pipeline, response and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDW'(NREQ - 1);
      start_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      tag_v_q      <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      start_q <= xfer;
      if (xfer) begin
        last_grant_q <= grant_id;
        a_q          <= sel_a;
        b_q          <= {sel_b[15] ^ sel_sub, sel_b[14:0]};
        id_q         <= grant_id;
      end
      tag_v_q <= tag_v_d;
      for (int unsigned k = 0; k < LAT; k++) tag_id_q[k] <= tag_id_d[k];
      rsp_valid_q <= add_done & tag_last_v;
      if (add_done && tag_last_v) begin
        rsp_id_q   <= tag_id_q[LAT-1];
        rsp_data_q <= add_y;
      end
      busy_q <= busy_d;
      if (add_done != tag_last_v) err_q <= 1'b1;
    end
  end

  assign add_start = start_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Directed bench: single-op table, back-to-back round robin, rejoin order,
// spurious done and mid-flight reset.
module tb_bf16_add_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_a;
  logic [16*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic                add_start;
  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic [15:0]         add_y;
  logic                add_done;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [15:0]         rsp_data;
  logic                busy;
  logic                err;

  int n_chk;
  int n_err;
  logic spur_done;

  bf16_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_y(add_y), .add_done(add_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: exact results for the bf16 pairs used, XOR otherwise.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_4000: return 16'h4040;  // 1 + 2 = 3
      32'h4040_BF80: return 16'h4000;  // 3 - 1 = 2
      32'h3F80_3F80: return 16'h4000;  // 1 + 1 = 2
      32'h4000_4000: return 16'h4080;  // 2 + 2 = 4
      32'h4000_BF80: return 16'h3F80;  // 2 - 1 = 1
      default:       return a ^ b;
    endcase
  endfunction

  logic        pipe_v [LAT];
  logic [15:0] pipe_y [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(LAT); k++) begin
        pipe_v[k] <= 1'b0;
        pipe_y[k] <= '0;
      end
    end else begin
      pipe_v[0] <= add_start;
      pipe_y[0] <= fadd(add_a, add_b);
      for (int k = 1; k < int'(LAT); k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_y[k] <= pipe_y[k-1];
      end
    end
  end

  assign add_done = pipe_v[LAT-1] | spur_done;
  assign add_y    = pipe_y[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_b;
    logic [15:0] exp_y;
  } vec_t;

  vec_t vecs [6];

  initial begin
    n_chk = 0;
    n_err = 0;
    spur_done = 1'b0;
    rst_n = 1'b0;
    req_valid = '1;
    req_sub = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[16*i +: 16] = 16'hA000 + 16'(i);
      req_b[16*i +: 16] = 16'hB000 + 16'(i);
    end

    vecs[0] = '{0, 16'h3F80, 16'h4000, 1'b0, 16'h4000, 16'h4040};
    vecs[1] = '{2, 16'h4040, 16'h3F80, 1'b1, 16'hBF80, 16'h4000};
    vecs[2] = '{1, 16'h3F80, 16'h3F80, 1'b0, 16'h3F80, 16'h4000};
    vecs[3] = '{3, 16'h4000, 16'h4000, 1'b0, 16'h4000, 16'h4080};
    vecs[4] = '{3, 16'h4000, 16'h3F80, 1'b1, 16'hBF80, 16'h3F80};
    vecs[5] = '{1, 16'h1234, 16'h00FF, 1'b0, 16'h00FF, 16'h12CB};

    // Reset state, with every requester asserting valid.
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_start", 32'(add_start), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_add_b", 32'(add_b), 32'h0);
    chk("rst_rsp", {15'(0), rsp_valid, 14'(0), rsp_id}, 32'h0);
    chk("rst_data", 32'(rsp_data), 32'h0);
    chk("rst_busy_err", {busy, err}, 32'h0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single-operation table.
    for (int v = 0; v < 6; v++) begin
      req_a[16*vecs[v].id +: 16] = vecs[v].a;
      req_b[16*vecs[v].id +: 16] = vecs[v].b;
      req_sub = '0;
      req_sub[vecs[v].id] = vecs[v].sub;
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      #1;
      chk("vec_ready", 32'(req_ready), 32'(req_valid));
      tick();
      req_valid = '0;
      chk("vec_start", 32'(add_start), 32'h1);
      chk("vec_add_a", 32'(add_a), 32'(vecs[v].a));
      chk("vec_add_b", 32'(add_b), 32'(vecs[v].exp_b));
      chk("vec_busy", 32'(busy), 32'h1);
      tick();
      chk("vec_start_off", 32'(add_start), 32'h0);
      chk("vec_hold_a", 32'(add_a), 32'(vecs[v].a));
      tick();
      tick();
      chk("vec_rsp_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp_y));
      tick();
      chk("vec_rsp_pulse", 32'(rsp_valid), 32'h0);
      chk("vec_idle", 32'(busy), 32'h0);
      for (int i = 0; i < int'(NREQ); i++) begin
        req_a[16*i +: 16] = 16'hA000 + 16'(i);
        req_b[16*i +: 16] = 16'hB000 + 16'(i);
      end
    end
    chk("no_err", 32'(err), 32'h0);

    // Fresh reset, then all requesters valid for 8 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[16*i +: 16] = 16'h1100 | 16'(i);
      req_b[16*i +: 16] = 16'h0022;
    end
    req_sub = '0;
    req_valid = '1;
    for (int c = 0; c < 14; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      chk("rr_ready", 32'(req_ready), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      chk("rr_start", 32'(add_start), (c >= 1 && c <= 8) ? 32'h1 : 32'h0);
      chk("rr_rsp_valid", 32'(rsp_valid), (c >= 5 && c <= 12) ? 32'h1 : 32'h0);
      if (c >= 5 && c <= 12) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'((c - 5) % 4));
        chk("rr_rsp_data", 32'(rsp_data), 32'(16'h1122 ^ 16'((c - 5) % 4)));
      end
      tick();
    end
    chk("rr_idle", {busy, err}, 32'h0);

    // Requester 1 alone, then 0 and 3 join: order 1, 3, 0, 1.
    req_valid = 4'b0010;
    #1;
    chk("join_g1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1011;
    #1;
    chk("join_g3", 32'(req_ready), 32'h8);
    tick();
    chk("join_g0", 32'(req_ready), 32'h1);
    tick();
    chk("join_g1b", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("join_idle", {busy, err}, 32'h0);

    // Spurious done on an empty pipeline.
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    chk("spur_err", 32'(err), 32'h1);
    chk("spur_rsp", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    chk("spur_sticky", 32'(err), 32'h1);
    chk("spur_rsp2", 32'(rsp_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("spur_rst", {busy, err}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset two cycles after a grant to requester 2.
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("mid_busy", 32'(busy), 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_start", 32'(add_start), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("mid_no_rsp", {busy, rsp_valid, err}, 32'h0);
    end
    req_valid = '1;
    #1;
    chk("mid_next_g0", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bf16_add_arbiter.md
BF16_ADD_ARBITER -- requirements
Module: bf16_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LAT, default 3, adder latency from start to done, in cycles.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot grant; the operation transfers when valid and ready are both high.
REQ-007 SHALL have port req_a  input  16*NREQ  operand A for requester i, at bits [16i+15:16i].
REQ-008 SHALL have port req_b  input  16*NREQ  operand B for requester i, same packing.
REQ-009 SHALL have port req_sub  input  NREQ  1 = compute A-B.
REQ-010 SHALL have port add_start  output  1  start pulse to the shared bf16 adder.
REQ-011 SHALL have port add_a  output  16  operand A to the adder.
REQ-012 SHALL have port add_b  output  16  operand B to the adder.
REQ-013 SHALL have port add_y  input  16  adder result.
REQ-014 SHALL have port add_done  input  1  adder result valid.
REQ-015 SHALL have port rsp_valid  output  1  one-cycle pulse when a result is returned.
REQ-016 SHALL have port rsp_id  output  clog2(NREQ)  requester that owns rsp_data.
REQ-017 SHALL have port rsp_data  output  16  bf16 result.
REQ-018 SHALL have port busy  output  1  high while any operation is issued but not yet returned.
REQ-019 SHALL have port err  output  1  sticky tag/done mismatch flag.

Function
REQ-020 Arbitration SHALL be round-robin, with at most one grant per cycle. The search starts at (last_grant+1) mod NREQ. last_grant updates only on a transfer.
REQ-021 req_ready SHALL be combinational from req_valid and last_grant, and zero when no requester is valid. No requester SHALL be starved for more than NREQ-1 grants.
REQ-022 For a transfer in cycle T, add_start SHALL be 1 in cycle T+1, with registered add_a=A and add_b=B. When sub=1, add_b SHALL equal B with bit15 inverted.
REQ-023 add_start SHALL be 0 in every cycle without a transfer in the previous cycle. add_a and add_b SHALL hold their last values.
REQ-024 The adder is fully pipelined, so back-to-back transfers SHALL issue back-to-back starts. There is no backpressure from the adder.
REQ-025 A tag shift register, LAT stages deep, SHALL carry {valid, id} alongside the adder pipeline. The stage-0 load SHALL coincide with add_start.
REQ-026 When add_done=1 and the final tag is valid, the block SHALL drive, in the next cycle: rsp_valid=1, rsp_id=tag id, rsp_data=add_y (registered; end-to-end latency LAT+2 from transfer).
REQ-027 Responses SHALL return in issue order. Requesters SHALL always accept rsp (no response backpressure).
REQ-028 If add_done differs from the final-tag valid in any cycle, err SHALL be set, and SHALL stay set until reset. On add_done with no valid tag, rsp_valid SHALL remain 0.
REQ-029 busy SHALL be the OR of the issue register valid and all tag stages valid.
REQ-030 A requester whose valid drops before transfer SHALL lose nothing. Operand changes while valid without ready are permitted but discouraged.

Reset
REQ-031 While rst_n=0, the block SHALL force the following state:
- req_ready=0, add_start=0, add_a=0, add_b=0;
- rsp_valid=0, rsp_id=0, rsp_data=0;
- busy=0, err=0;
- all tags invalid, last_grant=NREQ-1 (requester 0 wins first).
REQ-032 Reset mid-operation SHALL discard all in-flight tags. A late add_done after reset release with no tag SHALL set err; the integrating system resets the adder on the same rst_n to prevent this.

Verification
REQ-033 Single op: req0 A=0x3F80 (1.0), B=0x4000 (2.0) at T -> add_start at T+1, rsp_valid at T+5 with id=0, data=0x4040 (3.0).
REQ-034 Subtract: req2 A=0x4040, B=0x3F80, sub=1 -> add_b=0xBF80, rsp id=2, data=0x4000.
REQ-035 All four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, and 8 responses in the same id order 5 cycles later with add_start high 8 consecutive cycles.
REQ-036 Requester 1 only valid, then requester 0 and 3 join -> after grant 1 next grant is 3 then 0.
REQ-037 Inject spurious add_done with empty pipeline -> err=1 persists, rsp_valid stays 0; assert rst_n low -> err=0, busy=0.
REQ-038 Assert rst_n low two cycles after a grant -> no rsp_valid afterward, busy=0, next grant goes to requester 0.
